// File: rtl/addend_collector.sv
// Collects a frame of unsigned samples into a bank that feeds an adder tree directly.
// Define ADDEND_COLLECTOR_PINGPONG_EN to add a second bank so filling continues while a frame waits.
module addend_collector #(
    parameter int DATA_WIDTH = 8,
    parameter int LENGTH     = 42
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [DATA_WIDTH-1:0]       in_sample,
    input  logic                        in_valid,
    input  logic                        in_last,
    output logic                        in_ready,
    output logic [DATA_WIDTH-1:0]       out_addends [LENGTH],
    output logic [$clog2(LENGTH+1)-1:0] out_count,
    output logic                        out_valid,
    input  logic                        out_ready
);
    localparam int CNT_W = $clog2(LENGTH + 1);
    localparam int IDX_W = (LENGTH > 1) ? $clog2(LENGTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LENGTH - 1);
`ifdef ADDEND_COLLECTOR_PINGPONG_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    typedef enum logic {FILL = 1'b0, FULL = 1'b1} bank_state_t;

    bank_state_t           state [NB];
    logic [DATA_WIDTH-1:0] bank  [NB][LENGTH];
    logic [CNT_W-1:0]      cnt   [NB];
    logic [IDX_W-1:0]      wr_idx;
    logic                  wr_bank;
    logic                  rd_bank;
    logic                  run;
    logic                  accept;
    logic                  complete;
    logic                  rel;

    // in_ready depends only on registered state, so out_ready never reaches it combinationally
    assign in_ready  = run && (state[wr_bank] == FILL);
    assign out_valid = (state[rd_bank] == FULL);
    assign out_count = cnt[rd_bank];
    assign accept    = in_valid && in_ready;
    assign complete  = accept && (in_last || (wr_idx == LAST_IDX));
    assign rel       = out_valid && out_ready;

    always_comb begin
        for (int i = 0; i < LENGTH; i++) begin
            out_addends[i] = bank[rd_bank][i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run     <= 1'b0;
            wr_idx  <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            for (int b = 0; b < NB; b++) begin
                state[b] <= FILL;
                cnt[b]   <= '0;
                for (int i = 0; i < LENGTH; i++) begin
                    bank[b][i] <= '0;
                end
            end
        end else begin
            run <= 1'b1;
            // Released bank returns to all-zero so an early-terminated frame sums exactly
            if (rel) begin
                state[rd_bank] <= FILL;
                cnt[rd_bank]   <= '0;
                for (int i = 0; i < LENGTH; i++) begin
                    bank[rd_bank][i] <= '0;
                end
`ifdef ADDEND_COLLECTOR_PINGPONG_EN
                rd_bank <= ~rd_bank;
`endif
            end
            if (accept) begin
                bank[wr_bank][wr_idx] <= in_sample;
                cnt[wr_bank]          <= CNT_W'(wr_idx) + CNT_W'(1);
                if (complete) begin
                    state[wr_bank] <= FULL;
                    wr_idx         <= '0;
`ifdef ADDEND_COLLECTOR_PINGPONG_EN
                    wr_bank        <= ~wr_bank;
`endif
                end else begin
                    wr_idx <= wr_idx + IDX_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_addend_collector.sv
// Directed bench for addend_collector: LENGTH=4 instance for framing/backpressure/reset, LENGTH=1 instance for single-entry frames.
module tb_addend_collector;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [7:0] in_sample;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic [7:0] addends [4];
    logic [2:0] count;
    logic       out_valid;
    logic       out_ready;

    logic [7:0] s1;
    logic       v1;
    logic       l1;
    logic       r1;
    logic [7:0] a1 [1];
    logic [0:0] c1;
    logic       ov1;
    logic       or1;

    int errors = 0;
    int checks = 0;

    addend_collector #(.DATA_WIDTH(8), .LENGTH(4)) u4 (
        .clk(clk), .rst_n(rst_n), .in_sample(in_sample), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .out_addends(addends),
        .out_count(count), .out_valid(out_valid), .out_ready(out_ready)
    );

    addend_collector #(.DATA_WIDTH(8), .LENGTH(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_sample(s1), .in_valid(v1),
        .in_last(l1), .in_ready(r1), .out_addends(a1),
        .out_count(c1), .out_valid(ov1), .out_ready(or1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] s, input logic l);
        in_sample = s;
        in_last   = l;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        in_last   = 1'b0;
    endtask

    task automatic chk_frame(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3, input logic [2:0] n);
        chk({tag, ".valid"}, out_valid, 1'b1);
        chk({tag, ".a0"}, addends[0], e0);
        chk({tag, ".a1"}, addends[1], e1);
        chk({tag, ".a2"}, addends[2], e2);
        chk({tag, ".a3"}, addends[3], e3);
        chk({tag, ".count"}, count, n);
    endtask

    initial begin
        rst_n = 1'b0; in_sample = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        s1 = '0; v1 = 1'b0; l1 = 1'b0; or1 = 1'b1;
        tick();
        tick();
        chk("rst.valid", out_valid, 1'b0);
        chk("rst.ready", in_ready, 1'b0);
        chk("rst.count", count, 3'd0);
        chk("rst.a0", addends[0], 8'd0);
        rst_n = 1'b1;
        #1;
        chk("rst.ready_before_edge", in_ready, 1'b0);
        tick();
        chk("rst.ready_after_edge", in_ready, 1'b1);

        // Full frame streamed with consumer ready
        send(8'd10, 1'b0);
        send(8'd20, 1'b0);
        send(8'd30, 1'b0);
        chk("full.valid_early", out_valid, 1'b0);
        send(8'd40, 1'b0);
        chk_frame("full", 8'd10, 8'd20, 8'd30, 8'd40, 3'd4);
        chk("full.sum", 32'(addends[0]) + 32'(addends[1]) + 32'(addends[2]) + 32'(addends[3]), 32'd100);
`ifdef ADDEND_COLLECTOR_PINGPONG_EN
        chk("full.in_ready", in_ready, 1'b1);
`else
        chk("full.in_ready", in_ready, 1'b0);
`endif
        tick();
        chk("full.released", out_valid, 1'b0);
        chk("full.zeroed", addends[0], 8'd0);

        // Early termination on in_last
        send(8'd5, 1'b0);
        send(8'd7, 1'b1);
        chk_frame("early", 8'd5, 8'd7, 8'd0, 8'd0, 3'd2);
        tick();
        chk("early.released", out_valid, 1'b0);

        // Backpressure: frame held for 5 cycles while more input is offered
        out_ready = 1'b0;
        send(8'd1, 1'b0);
        send(8'd2, 1'b0);
        send(8'd3, 1'b0);
        send(8'd4, 1'b0);
        for (int i = 0; i < 5; i++) begin
            in_sample = 8'(11 + i);
            in_valid  = 1'b1;
            tick();
            chk("hold.valid", out_valid, 1'b1);
            chk("hold.a0", addends[0], 8'd1);
            chk("hold.a3", addends[3], 8'd4);
            chk("hold.count", count, 3'd4);
        end
        in_valid = 1'b0;
        chk("hold.in_ready", in_ready, 1'b0);
        out_ready = 1'b1;
        tick();
`ifdef ADDEND_COLLECTOR_PINGPONG_EN
        chk_frame("second", 8'd11, 8'd12, 8'd13, 8'd14, 3'd4);
        tick();
`endif
        chk("hold.drained", out_valid, 1'b0);

        // Reset in the middle of a frame
        send(8'd77, 1'b0);
        send(8'd88, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst.valid", out_valid, 1'b0);
        chk("midrst.count", count, 3'd0);
        chk("midrst.a0", addends[0], 8'd0);
        chk("midrst.a1", addends[1], 8'd0);
        chk("midrst.in_ready", in_ready, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("midrst.ready_back", in_ready, 1'b1);
        chk("midrst.no_output", out_valid, 1'b0);
        send(8'd1, 1'b0);
        send(8'd2, 1'b0);
        send(8'd3, 1'b0);
        send(8'd4, 1'b0);
        chk_frame("postrst", 8'd1, 8'd2, 8'd3, 8'd4, 3'd4);
        tick();

        // in_last coinciding with the final index yields exactly one frame
        send(8'd9, 1'b0);
        send(8'd9, 1'b0);
        send(8'd9, 1'b0);
        send(8'd9, 1'b1);
        chk_frame("lastfull", 8'd9, 8'd9, 8'd9, 8'd9, 3'd4);
        tick();
        chk("lastfull.gone", out_valid, 1'b0);
        tick();
        tick();
        chk("lastfull.no_empty", out_valid, 1'b0);
        chk("lastfull.ready", in_ready, 1'b1);

        // LENGTH=1: every sample is its own frame
`ifdef ADDEND_COLLECTOR_PINGPONG_EN
        v1 = 1'b1; s1 = 8'd255;
        tick();
        chk("len1.v0", ov1, 1'b1); chk("len1.a0", a1[0], 8'd255); chk("len1.c0", c1, 1'b1);
        s1 = 8'd0;
        tick();
        chk("len1.v1", ov1, 1'b1); chk("len1.a1", a1[0], 8'd0); chk("len1.c1", c1, 1'b1);
        s1 = 8'd3;
        tick();
        chk("len1.v2", ov1, 1'b1); chk("len1.a2", a1[0], 8'd3); chk("len1.c2", c1, 1'b1);
        v1 = 1'b0;
        tick();
        chk("len1.done", ov1, 1'b0);
`else
        v1 = 1'b1; s1 = 8'd255;
        tick();
        v1 = 1'b0;
        chk("len1.v0", ov1, 1'b1); chk("len1.a0", a1[0], 8'd255); chk("len1.c0", c1, 1'b1);
        chk("len1.busy", r1, 1'b0);
        tick();
        chk("len1.free", r1, 1'b1);
        v1 = 1'b1; s1 = 8'd0;
        tick();
        v1 = 1'b0;
        chk("len1.v1", ov1, 1'b1); chk("len1.a1", a1[0], 8'd0); chk("len1.c1", c1, 1'b1);
        tick();
        v1 = 1'b1; s1 = 8'd3;
        tick();
        v1 = 1'b0;
        chk("len1.v2", ov1, 1'b1); chk("len1.a2", a1[0], 8'd3); chk("len1.c2", c1, 1'b1);
        tick();
        chk("len1.done", ov1, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
